dff_response_checker: RTL and testbench

- Synthesizable self-checking monitor that sits on the output side of a D-type flip-flop under test (clk, rst, d in; q, qbar out).
- It observes the same d stimulus the DUT receives and predicts q through a LATENCY-deep model pipeline.
- Each cycle it compares the DUT's q/qbar against the prediction, then counts checks and errors and latches the first failure.
- It sits beside the DUT in the bench or on-chip BIST wrapper and replaces manual waveform inspection.

---
 rtl/dff_response_checker.sv | 142 ++++++++++++++
 tb/tb_dff_response_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
// Monitor that watches a D flip-flop's q/qbar and compares them with a LATENCY-deep model of d.
// Keeps saturating counts of compares and failures and records the check index of the first failure.
//
// state  | meaning
// IDLE   | not comparing; waiting for enable
// CHECK  | comparing every edge with enable high; no failure seen yet
// FAIL   | a compare has failed; still compares while enabled, left only by clear_err or rst
module dff_response_checker #(
    parameter int   CNT_W   = 8,
    parameter int   LATENCY = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear_err,
    input  logic             d,
    input  logic             q,
    input  logic             qbar,
    output logic             checking,
    output logic             mismatch,
    output logic             qbar_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_FAIL  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [LATENCY-1:0] exp_q, exp_d;
    logic               mismatch_q, mismatch_d;
    logic               qbar_err_q, qbar_err_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   ffi_q, ffi_d;

    logic exp_bit;
    logic qbar_bad;
    logic fail;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Case inequality so an X/Z on the DUT outputs counts as a failure in simulation.
    assign exp_bit  = exp_q[LATENCY-1];
    assign qbar_bad = (qbar !== ~q);
    assign fail     = (q !== exp_bit) || qbar_bad;

    always_comb begin
        exp_d    = exp_q << 1;
        exp_d[0] = d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_err) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = fail ? ST_FAIL : ST_CHECK;
                end
                ST_CHECK: begin
                    if (!enable)   state_d = ST_IDLE;
                    else if (fail) state_d = ST_FAIL;
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mismatch_d = 1'b0;
        qbar_err_d = 1'b0;
        sticky_d   = sticky_q;
        chk_cnt_d  = chk_cnt_q;
        err_cnt_d  = err_cnt_q;
        ffi_d      = ffi_q;
        if (clear_err) begin
            sticky_d  = 1'b0;
            chk_cnt_d = '0;
            err_cnt_d = '0;
            ffi_d     = '0;
        end else if (enable) begin
            chk_cnt_d  = sat_inc(chk_cnt_q);
            mismatch_d = fail;
            qbar_err_d = qbar_bad;
            if (fail) begin
                err_cnt_d = sat_inc(err_cnt_q);
                if (!sticky_q) begin
                    sticky_d = 1'b1;
                    ffi_d    = chk_cnt_q;
                end
            end
        end
    end

    // The model pipeline shifts regardless of enable and clear_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= {LATENCY{RST_VAL}};
        end else begin
            exp_q <= exp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mismatch_q <= 1'b0;
            qbar_err_q <= 1'b0;
            sticky_q   <= 1'b0;
            chk_cnt_q  <= '0;
            err_cnt_q  <= '0;
            ffi_q      <= '0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            qbar_err_q <= qbar_err_d;
            sticky_q   <= sticky_d;
            chk_cnt_q  <= chk_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ffi_q      <= ffi_d;
        end
    end

    assign checking       = (state_q == ST_CHECK) || (state_q == ST_FAIL);
    assign mismatch       = mismatch_q;
    assign qbar_err       = qbar_err_q;
    assign err_sticky     = sticky_q;
    assign check_count    = chk_cnt_q;
    assign err_count      = err_cnt_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: a behavioural DFF with injectable faults feeds two checker instances,
// whose outputs are compared every edge against a history-based reference model.
module tb_dff_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic clear_err = 1'b0;
    logic d = 1'b0;
    logic fq0 = 1'b0;
    logic fqb = 1'b0;
    logic q_ff;
    logic q, qbar;

    always #5 clk = ~clk;

    // Flip-flop under test, with a stuck-at-0 q fault and a qbar==q fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_ff <= 1'b0;
        else     q_ff <= d;
    end
    assign q    = fq0 ? 1'b0 : q_ff;
    assign qbar = fqb ? q : ~q;

    logic       a_chk, a_mis, a_qbe, a_stk;
    logic [7:0] a_cc, a_ec, a_ffi;
    logic       b_chk, b_mis, b_qbe, b_stk;
    logic [1:0] b_cc, b_ec, b_ffi;

    dff_response_checker #(.CNT_W(8), .LATENCY(1), .RST_VAL(1'b0)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err), .d(d), .q(q), .qbar(qbar),
        .checking(a_chk), .mismatch(a_mis), .qbar_err(a_qbe), .err_sticky(a_stk),
        .check_count(a_cc), .err_count(a_ec), .first_fail_idx(a_ffi)
    );

    dff_response_checker #(.CNT_W(2), .LATENCY(3), .RST_VAL(1'b1)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err), .d(d), .q(q), .qbar(qbar),
        .checking(b_chk), .mismatch(b_mis), .qbar_err(b_qbe), .err_sticky(b_stk),
        .check_count(b_cc), .err_count(b_ec), .first_fail_idx(b_ffi)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected q is simply d from LATENCY edges ago, or the reset value.
    int  lat [2] = '{1, 3};
    int  cmax[2] = '{255, 3};
    bit  rval[2] = '{1'b0, 1'b1};
    bit  dh[$];
    int  m_cc[2], m_ec[2], m_ffi[2];
    bit  m_chk[2], m_mis[2], m_qbe[2], m_stk[2], m_failst[2];

    task automatic model_reset();
        dh.delete();
        for (int i = 0; i < 2; i++) begin
            m_cc[i] = 0; m_ec[i] = 0; m_ffi[i] = 0;
            m_chk[i] = 0; m_mis[i] = 0; m_qbe[i] = 0; m_stk[i] = 0; m_failst[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit e, qb_bad, bad;
        for (int i = 0; i < 2; i++) begin
            e      = (dh.size() >= lat[i]) ? dh[dh.size() - lat[i]] : rval[i];
            qb_bad = (qbar == q);
            bad    = (q != e) || qb_bad;
            m_mis[i] = 0;
            m_qbe[i] = 0;
            if (clear_err) begin
                m_cc[i] = 0; m_ec[i] = 0; m_ffi[i] = 0;
                m_stk[i] = 0; m_failst[i] = 0; m_chk[i] = 0;
            end else if (enable) begin
                if (bad && !m_stk[i]) begin
                    m_ffi[i] = m_cc[i];
                    m_stk[i] = 1;
                end
                if (m_cc[i] < cmax[i]) m_cc[i]++;
                if (bad && m_ec[i] < cmax[i]) m_ec[i]++;
                m_mis[i] = bad;
                m_qbe[i] = qb_bad;
                if (bad) m_failst[i] = 1;
                m_chk[i] = 1;
            end else begin
                m_chk[i] = m_failst[i];
            end
        end
        dh.push_back(d);
    endtask

    task automatic check_all();
        check_val("a_checking", a_chk, m_chk[0]);
        check_val("a_mismatch", a_mis, m_mis[0]);
        check_val("a_qbar_err", a_qbe, m_qbe[0]);
        check_val("a_sticky",   a_stk, m_stk[0]);
        check_val("a_chk_cnt",  a_cc,  m_cc[0]);
        check_val("a_err_cnt",  a_ec,  m_ec[0]);
        check_val("a_ffi",      a_ffi, m_ffi[0]);
        check_val("b_checking", b_chk, m_chk[1]);
        check_val("b_mismatch", b_mis, m_mis[1]);
        check_val("b_qbar_err", b_qbe, m_qbe[1]);
        check_val("b_sticky",   b_stk, m_stk[1]);
        check_val("b_chk_cnt",  b_cc,  m_cc[1]);
        check_val("b_err_cnt",  b_ec,  m_ec[1]);
        check_val("b_ffi",      b_ffi, m_ffi[1]);
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step(input logic dv, input logic en, input logic clr, input logic f0, input logic fb);
        d = dv; enable = en; clear_err = clr; fq0 = f0; fqb = fb;
        #1;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0; clear_err = 1'b0; fq0 = 1'b0; fqb = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Clean run with d = 0,1,1,0
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check_val("p1_cnt", a_cc, 4);
        check_val("p1_err", a_ec, 0);
        check_val("p1_sticky", a_stk, 0);

        // q stuck at 0 with d=1 from edge 2
        do_reset();
        step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        check_val("p2_mis", a_mis, 1);
        check_val("p2_ffi", a_ffi, 2);
        check_val("p2_sticky", a_stk, 1);
        step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        check_val("p2_err", a_ec, 2);
        step(0, 0, 0, 1, 0);
        check_val("p2_fail_held", a_chk, 1);

        // qbar == q once while q is correct
        do_reset();
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        check_val("p3_qbe", a_qbe, 1);
        check_val("p3_mis", a_mis, 1);
        step(1, 1, 0, 0, 0);
        check_val("p3_err", a_ec, 1);
        check_val("p3_qbe_pulse", a_qbe, 0);

        // Reset mid-run after 5 checks with 2 errors
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check_val("p4_cnt", a_cc, 5);
        check_val("p4_err", a_ec, 2);
        do_reset();
        check_val("p4_rst_cnt", a_cc, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // clear_err on the same edge as a failing compare
        do_reset();
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        check_val("p5_cnt", a_cc, 0);
        check_val("p5_sticky", a_stk, 0);
        check_val("p5_idle", a_chk, 0);
        check_val("p5_mis", a_mis, 0);

        // Saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 6; k++) step(logic'($urandom_range(0, 1)), 1, 0, 0, 1);
        check_val("p6_b_cnt", b_cc, 3);
        check_val("p6_b_err", b_ec, 3);
        check_val("p6_b_ffi", b_ffi, 0);
        check_val("p6_b_mis", b_mis, 1);
        check_val("p6_a_cnt", a_cc, 6);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(logic'($urandom_range(0, 1)),
                     logic'($urandom_range(0, 7) != 0),
                     logic'($urandom_range(0, 31) == 0),
                     logic'($urandom_range(0, 9) == 0),
                     logic'($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
